// File: rtl/regfile_sb.sv
// regfile_sb -- general-purpose register file with operand forwarding and a
// busy scoreboard for long-latency results.
//
// Reads are combinational and see, in priority order: the hard-wired zero
// register, the EX stage result, the MEM stage result, the byte-merged
// writeback data in flight this cycle, and finally the stored register.
// A busy bit per register tracks long-latency ops that have issued but not
// yet written back. stallreq tells the decode stage that one of its live
// operands cannot be supplied this cycle.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   ren, raddr        per-port read valid and packed read addresses
//   rdata             packed forwarded read data (port p at [p*DATA_W +: DATA_W])
//   we, waddr, wdata  writeback byte enables, address and data
//   ex_*, mem_*       in-flight stage results; *_nofwd = not forwardable yet
//   iss_valid/addr    long-latency op issued and its destination
//   wb_done           this writeback completes a long-latency op
//   id_is_branch      decode stage holds a branch
//   stallreq          decode must hold
//   br_fwd_vld/data   registered EX bypass for the branch unit, valid one cycle
//   busy_cnt          number of busy registers
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NREG     = 32,
  parameter int RD_PORTS = 2,
  localparam int AW      = $clog2(NREG),
  localparam int NB      = DATA_W / 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RD_PORTS-1:0]        ren,
  input  logic [RD_PORTS*AW-1:0]     raddr,
  output logic [RD_PORTS*DATA_W-1:0] rdata,
  input  logic [NB-1:0]              we,
  input  logic [AW-1:0]              waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       ex_wen,
  input  logic [AW-1:0]              ex_waddr,
  input  logic [DATA_W-1:0]          ex_wdata,
  input  logic                       ex_nofwd,
  input  logic                       mem_wen,
  input  logic [AW-1:0]              mem_waddr,
  input  logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_nofwd,
  input  logic                       iss_valid,
  input  logic [AW-1:0]              iss_addr,
  input  logic                       wb_done,
  input  logic                       id_is_branch,
  output logic                       stallreq,
  output logic [RD_PORTS-1:0]        br_fwd_vld,
  output logic [DATA_W-1:0]          br_fwd_data,
  output logic [AW:0]                busy_cnt
);

  logic [DATA_W-1:0]   gpr [NREG];
  logic [NREG-1:0]     busy;
  logic [NREG-1:0]     busy_next;
  logic [RD_PORTS-1:0] ex_hit;
  logic [RD_PORTS-1:0] port_stall;
  logic                wb_any;

  assign wb_any = |we;

  // Per-port forwarding and hazard detection
  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    logic [AW-1:0]     ra;
    logic              nonzero;
    logic              mem_hit;
    logic              wb_hit;
    logic              busy_hit;
    logic [DATA_W-1:0] merged;

    assign ra       = raddr[p*AW +: AW];
    assign nonzero  = (ra != '0);
    assign ex_hit[p] = nonzero && ex_wen && (ex_waddr == ra);
    assign mem_hit  = nonzero && mem_wen && (mem_waddr == ra);
    assign wb_hit   = nonzero && wb_any && (waddr == ra);

    // Writeback bypass: enabled bytes from wdata, the rest from the array
    always_comb begin
      merged = gpr[ra];
      for (int b = 0; b < NB; b++) begin
        if (we[b]) merged[b*8 +: 8] = wdata[b*8 +: 8];
      end
    end

    assign rdata[p*DATA_W +: DATA_W] = !nonzero ? '0 :
                                       ex_hit[p] ? ex_wdata :
                                       mem_hit   ? mem_wdata :
                                       wb_hit    ? merged :
                                                   gpr[ra];

    // A busy register is not a hazard if its completing writeback is
    // happening right now: the bypass above already supplies the value.
    assign busy_hit = busy[ra] && !(wb_done && wb_hit);

    assign port_stall[p] = ren[p] && nonzero &&
                           ((ex_hit[p] && ex_nofwd) ||
                            (mem_hit && mem_nofwd) ||
                            (ex_hit[p] && id_is_branch) ||
                            busy_hit);
  end

  assign stallreq = |port_stall;

  // Scoreboard next state: clear first so a same-edge issue wins
  always_comb begin
    busy_next = busy;
    if (wb_done && wb_any) busy_next[waddr] = 1'b0;
    if (iss_valid && (iss_addr != '0)) busy_next[iss_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < NREG; i++) begin
      busy_cnt = busy_cnt + {{AW{1'b0}}, busy[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
    end else if (wb_any && (waddr != '0)) begin
      for (int b = 0; b < NB; b++) begin
        if (we[b]) gpr[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= '0;
      br_fwd_vld  <= '0;
      br_fwd_data <= '0;
    end else begin
      busy        <= busy_next;
      br_fwd_vld  <= ex_hit & ren & {RD_PORTS{id_is_branch}};
      br_fwd_data <= ex_wdata;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int DATA_W   = 32;
  localparam int NREG     = 32;
  localparam int RD_PORTS = 2;
  localparam int AW       = 5;
  localparam int NB       = 4;

  logic                       clk;
  logic                       rst;
  logic [RD_PORTS-1:0]        ren;
  logic [RD_PORTS*AW-1:0]     raddr;
  logic [RD_PORTS*DATA_W-1:0] rdata;
  logic [NB-1:0]              we;
  logic [AW-1:0]              waddr;
  logic [DATA_W-1:0]          wdata;
  logic                       ex_wen, mem_wen, ex_nofwd, mem_nofwd;
  logic [AW-1:0]              ex_waddr, mem_waddr;
  logic [DATA_W-1:0]          ex_wdata, mem_wdata;
  logic                       iss_valid, wb_done, id_is_branch;
  logic [AW-1:0]              iss_addr;
  logic                       stallreq;
  logic [RD_PORTS-1:0]        br_fwd_vld;
  logic [DATA_W-1:0]          br_fwd_data;
  logic [AW:0]                busy_cnt;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [DATA_W-1:0] model_gpr [NREG];

  regfile_sb #(.DATA_W(DATA_W), .NREG(NREG), .RD_PORTS(RD_PORTS)) dut (
    .clk(clk), .rst(rst), .ren(ren), .raddr(raddr), .rdata(rdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .ex_wen(ex_wen), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_nofwd(ex_nofwd),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_nofwd(mem_nofwd),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .wb_done(wb_done),
    .id_is_branch(id_is_branch), .stallreq(stallreq),
    .br_fwd_vld(br_fwd_vld), .br_fwd_data(br_fwd_data), .busy_cnt(busy_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input string tag, input logic [63:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: scoreboard empty, got %h expected none", tag, obs);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    ren = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
    ex_wen = 0; ex_waddr = '0; ex_wdata = '0; ex_nofwd = 0;
    mem_wen = 0; mem_waddr = '0; mem_wdata = '0; mem_nofwd = 0;
    iss_valid = 0; iss_addr = '0; wb_done = 0; id_is_branch = 0;
  endtask

  task automatic set_read(input int p, input logic [AW-1:0] a);
    ren[p] = 1'b1;
    raddr[p*AW +: AW] = a;
  endtask

  function automatic logic [DATA_W-1:0] port_data(input int p);
    return rdata[p*DATA_W +: DATA_W];
  endfunction

  // Drive a writeback and update the reference model in the same step
  task automatic drive_wb(input logic [AW-1:0] a, input logic [NB-1:0] e,
                          input logic [DATA_W-1:0] d, input logic done);
    we = e; waddr = a; wdata = d; wb_done = done;
    if (a != 0) begin
      for (int b = 0; b < NB; b++)
        if (e[b]) model_gpr[a][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) model_gpr[i] = '0;
  endtask

  initial begin
    logic [AW-1:0] ra0, ra1, wa;
    logic [NB-1:0] be;
    logic [DATA_W-1:0] d;

    idle_inputs();
    model_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    set_read(0, 5'd5);
    settle();
    check("rst_busy_cnt", busy_cnt, 0);
    check("rst_br_vld", br_fwd_vld, 0);
    check("rst_br_data", br_fwd_data, 0);
    check("rst_stall", stallreq, 0);
    sb_push(0); sb_check("rst_rd5", port_data(0));

    // Byte-enable writeback with same-cycle bypass
    drive_wb(5'd5, 4'hF, 32'h11223344, 0);
    tick();
    drive_wb(5'd5, 4'b0101, 32'hAABBCCDD, 0);
    settle();
    sb_push(32'h11BB33DD); sb_check("be_bypass", port_data(0));
    tick();
    we = '0;
    settle();
    sb_push(32'h11BB33DD); sb_check("be_stored", port_data(0));
    sb_push(model_gpr[5]); sb_check("be_model", port_data(0));

    // Writes to r0 are discarded
    drive_wb(5'd0, 4'hF, 32'hDEADBEEF, 0);
    tick();
    we = '0;
    set_read(1, 5'd0);
    settle();
    sb_push(0); sb_check("r0_write", port_data(1));

    // EX over MEM over WB priority
    idle_inputs();
    set_read(0, 5'd3);
    ex_wen = 1; ex_waddr = 5'd3; ex_wdata = 32'd7;
    mem_wen = 1; mem_waddr = 5'd3; mem_wdata = 32'd9;
    we = 4'hF; waddr = 5'd3; wdata = 32'h55;
    settle();
    sb_push(7); sb_check("pri_ex", port_data(0));
    check("pri_ex_nostall", stallreq, 0);
    ex_nofwd = 1;
    settle();
    check("ex_nofwd_stall", stallreq, 1);
    ex_nofwd = 0; ex_wen = 0;
    settle();
    sb_push(9); sb_check("pri_mem", port_data(0));
    mem_nofwd = 1;
    settle();
    check("mem_nofwd_stall", stallreq, 1);
    mem_nofwd = 0; mem_wen = 0;
    settle();
    sb_push(32'h55); sb_check("pri_wb", port_data(0));
    ren = '0;
    mem_nofwd = 1; mem_wen = 1;
    settle();
    check("ren0_no_stall", stallreq, 0);
    idle_inputs();
    we = '0;

    // Busy scoreboard
    iss_valid = 1; iss_addr = 5'd8;
    tick();
    iss_valid = 0;
    set_read(0, 5'd8);
    settle();
    check("busy_cnt_1", busy_cnt, 1);
    check("busy_stall", stallreq, 1);
    drive_wb(5'd8, 4'hF, 32'h0000CAFE, 1);
    settle();
    check("busy_clear_nostall", stallreq, 0);
    sb_push(32'h0000CAFE); sb_check("busy_wb_bypass", port_data(0));
    tick();
    idle_inputs();
    settle();
    check("busy_cnt_0", busy_cnt, 0);

    // Same-edge issue and clear: issue wins
    iss_valid = 1; iss_addr = 5'd9;
    tick();
    drive_wb(5'd9, 4'hF, 32'h99, 1);
    tick();
    idle_inputs();
    settle();
    check("set_wins_cnt", busy_cnt, 1);
    set_read(1, 5'd9);
    settle();
    check("set_wins_stall", stallreq, 1);
    drive_wb(5'd9, 4'h1, 32'h9A, 1);
    tick();
    idle_inputs();
    settle();
    check("clear9_cnt", busy_cnt, 0);
    // Issue to r0 never sets a bit
    iss_valid = 1; iss_addr = 5'd0;
    tick();
    idle_inputs();
    settle();
    check("iss_r0_cnt", busy_cnt, 0);

    // Branch bypass on port 1
    id_is_branch = 1;
    set_read(1, 5'd7);
    ex_wen = 1; ex_waddr = 5'd7; ex_wdata = 32'h40;
    settle();
    check("br_stall", stallreq, 1);
    tick();
    idle_inputs();
    settle();
    check("br_vld_next", br_fwd_vld, 2'b10);
    check("br_data_next", br_fwd_data, 32'h40);
    tick();
    check("br_vld_clear", br_fwd_vld, 0);

    // Reset mid-operation overrides writeback and issue
    iss_valid = 1; iss_addr = 5'd4;
    tick();
    iss_addr = 5'd6;
    tick();
    iss_valid = 0;
    settle();
    check("pre_rst_cnt", busy_cnt, 2);
    rst = 1;
    we = 4'hF; waddr = 5'd4; wdata = 32'h1234; wb_done = 1;
    iss_valid = 1; iss_addr = 5'd10;
    ex_wen = 1; ex_waddr = 5'd2; ex_wdata = 32'h77; id_is_branch = 1;
    set_read(0, 5'd2);
    tick();
    rst = 0;
    idle_inputs();
    model_reset();
    set_read(0, 5'd4);
    set_read(1, 5'd5);
    settle();
    check("post_rst_cnt", busy_cnt, 0);
    check("post_rst_stall", stallreq, 0);
    check("post_rst_br_vld", br_fwd_vld, 0);
    check("post_rst_br_data", br_fwd_data, 0);
    sb_push(0); sb_check("post_rst_r4", port_data(0));
    sb_push(0); sb_check("post_rst_r5", port_data(1));
    ex_wen = 1; ex_waddr = 5'd0; ex_wdata = 32'hFF;
    set_read(0, 5'd0); set_read(1, 5'd0);
    settle();
    sb_push(0); sb_check("r0_ex_p0", port_data(0));
    sb_push(0); sb_check("r0_ex_p1", port_data(1));
    idle_inputs();

    // Random writes checked against the reference model
    for (int n = 0; n < 40; n++) begin
      wa = AW'($urandom_range(1, NREG - 1));
      be = NB'($urandom_range(0, 15));
      d  = $urandom;
      drive_wb(wa, be, d, 0);
      tick();
      we = '0;
      ra0 = wa;
      ra1 = AW'($urandom_range(0, NREG - 1));
      set_read(0, ra0);
      set_read(1, ra1);
      sb_push(model_gpr[ra0]);
      sb_push(model_gpr[ra1]);
      settle();
      sb_check("rand_p0", port_data(0));
      sb_check("rand_p1", port_data(1));
      idle_inputs();
    end

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
